apb_cfg_master: RTL and testbench

- APB initiator that turns a valid/ready command stream (addr, data, read/write) into single APB transfers toward the accelerator's configuration register slave.
- Returns one response per command (read data, slave error, timeout) on a valid/ready response channel.
- Sits between the host-side command source (sequencer or test driver) and the register slave. Only one transfer is outstanding at a time.

---
 rtl/apb_cfg_master_pkg.sv | 35 +++
 rtl/apb_cfg_master_if.sv | 66 ++++++
 rtl/apb_cfg_master.sv | 192 +++++++++++++++++++
 tb/tb_apb_cfg_master.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cfg_master_pkg.sv
// apb_cfg_master_pkg
//   Shared definitions for the APB configuration master, the register slave
//   and their benches: FSM state encoding, APB bus widths and the register
//   offset map of the accelerator configuration block.
//   No ports (package).

package apb_cfg_master_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Transfer sequencer states. Exactly one transfer is in flight between
  // leaving IDLE and returning to it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Configuration register offsets on the slave side.
  localparam logic [APB_ADDR_W-1:0] REG_WEIGHT_XFER = 32'h0000_0000;
  localparam logic [APB_ADDR_W-1:0] REG_LAST_ROW    = 32'h0000_0004;
  localparam logic [APB_ADDR_W-1:0] REG_LAST_COL    = 32'h0000_0008;
  localparam logic [APB_ADDR_W-1:0] REG_SYS_START   = 32'h0000_000C;
  localparam logic [APB_ADDR_W-1:0] REG_ACT_ADDR    = 32'h0000_0010;
  localparam logic [APB_ADDR_W-1:0] REG_BATCH       = 32'h0000_0014;

  // Width of a counter that must be able to hold the value 'limit'.
  // A limit of 0 still gets a 1-bit counter so the logic stays legal.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_cfg_master_if.sv
// apb_cfg_master_if
//   Bundles the three channels handled by apb_cfg_master:
//     cmd_*    : command stream from the host side (valid/ready)
//     rsp_*    : one response per command back to the host (valid/ready)
//     m_apb_*  : APB initiator signals toward the configuration slave
//   Modports:
//     master : the view of apb_cfg_master (drives cmd_ready, rsp_*, APB
//              request signals; receives commands and APB completion)
//     slave  : the view of the surrounding environment (command source,
//              response sink and APB register slave)
//
// Handshake rule for cmd and rsp channels: a beat transfers on the rising
// clock edge where valid and ready are both 1. Once valid is raised the
// payload stays stable and valid stays high until that edge; ready may be
// raised or dropped at any time and never depends combinationally on valid.

interface apb_cfg_master_if
  import apb_cfg_master_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  // APB initiator
  logic [ADDR_W-1:0] m_apb_paddr;
  logic              m_apb_psel;
  logic              m_apb_penable;
  logic              m_apb_pwrite;
  logic [DATA_W-1:0] m_apb_pwdata;
  logic              m_apb_pready;
  logic [DATA_W-1:0] m_apb_prdata;
  logic              m_apb_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pwdata,
    input  m_apb_pready, m_apb_prdata, m_apb_pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pwdata,
    output m_apb_pready, m_apb_prdata, m_apb_pslverr
  );

endinterface

// File: rtl/apb_cfg_master.sv
// apb_cfg_master
//   APB initiator that converts a valid/ready command stream into single APB
//   transfers and returns exactly one response per command (read data, slave
//   error or timeout). Only one transfer is outstanding at a time, so the
//   best-case throughput is one command every four cycles.
//
// Ports:
//   clk          system clock, all logic on posedge
//   resetn       synchronous reset, active HIGH despite the name
//   bus          apb_cfg_master_if.master: cmd_*, rsp_* and m_apb_* channels
//   o_dbg_state  current FSM state, for observation only
//
// Parameters:
//   ADDR_W   command / APB address width
//   DATA_W   command / APB data width
//   TIMEOUT  ACCESS cycles allowed without pready before aborting; 0 = never

module apb_cfg_master
  import apb_cfg_master_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  apb_cfg_master_if.master      bus,
  output state_e                o_dbg_state
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // The abort fires on the ACCESS cycle whose count before increment is
  // TIMEOUT-1, so exactly TIMEOUT ACCESS cycles are spent waiting.
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  // ---------------------------------------------------------------------
  // state and registered outputs
  // ---------------------------------------------------------------------
  state_e              r_state;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_timeout;
  logic [CNT_W-1:0]    r_cnt;

  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   w_paddr_nxt;
  logic                w_psel_nxt;
  logic                w_penable_nxt;
  logic                w_pwrite_nxt;
  logic [DATA_W-1:0]   w_pwdata_nxt;
  logic                w_rsp_valid_nxt;
  logic [DATA_W-1:0]   w_rsp_rdata_nxt;
  logic                w_rsp_err_nxt;
  logic                w_rsp_timeout_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic                w_limit;

  // Limit reached on this ACCESS cycle. A pready in the same cycle takes
  // priority, which the ACCESS branch below enforces by testing pready first.
  assign w_limit = TO_EN && (r_cnt == LIMIT_M1);

  // ---------------------------------------------------------------------
  // next-state and next-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_paddr_nxt       = r_paddr;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_pwrite_nxt      = r_pwrite;
    w_pwdata_nxt      = r_pwdata;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_cnt_nxt         = r_cnt;

    unique case (r_state)
      IDLE: begin
        // cmd_ready is high throughout IDLE, so cmd_valid alone is the handshake.
        if (bus.cmd_valid) begin
          w_paddr_nxt   = bus.cmd_addr;
          w_pwrite_nxt  = bus.cmd_write;
          w_pwdata_nxt  = bus.cmd_write ? bus.cmd_wdata : '0;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = SETUP;
        end
      end

      SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = ACCESS;
      end

      ACCESS: begin
        if (bus.m_apb_pready) begin
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = r_pwrite ? '0 : bus.m_apb_prdata;
          w_rsp_err_nxt     = bus.m_apb_pslverr;
          w_rsp_timeout_nxt = 1'b0;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_state_nxt       = RESP;
        end else begin
          if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          if (w_limit) begin
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_rdata_nxt   = '0;
            w_rsp_err_nxt     = 1'b1;
            w_rsp_timeout_nxt = 1'b1;
            w_psel_nxt        = 1'b0;
            w_penable_nxt     = 1'b0;
            w_state_nxt       = RESP;
          end
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (resetn) begin
      // Mid-transfer reset drops psel/penable and discards any response.
      r_state       <= IDLE;
      r_paddr       <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_paddr       <= w_paddr_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // outputs
  // ---------------------------------------------------------------------
  // cmd_ready is a pure state decode: no path from cmd_valid.
  assign bus.cmd_ready     = (r_state == IDLE);
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_rdata     = r_rsp_rdata;
  assign bus.rsp_err       = r_rsp_err;
  assign bus.rsp_timeout   = r_rsp_timeout;
  assign bus.m_apb_paddr   = r_paddr;
  assign bus.m_apb_psel    = r_psel;
  assign bus.m_apb_penable = r_penable;
  assign bus.m_apb_pwrite  = r_pwrite;
  assign bus.m_apb_pwdata  = r_pwdata;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_apb_cfg_master.sv
// tb_apb_cfg_master
//   Self-checking bench for apb_cfg_master (TIMEOUT=8). The bench plays the
//   command source, response sink and APB slave. Expected responses are
//   pushed to exp_q when a command is issued and popped at the response
//   handshake. Inputs change 1 time unit after posedge; outputs are sampled
//   at the same point.

module tb_apb_cfg_master;
  import apb_cfg_master_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int W       = DATA_W + 2;   // {timeout, err, rdata}

  // ---------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------
  logic   clk    = 1'b0;
  logic   resetn = 1'b1;
  state_e dbg_state;

  always #5 clk = ~clk;

  apb_cfg_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_cfg_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid     = 1'b0;
    bus.cmd_write     = 1'b0;
    bus.cmd_addr      = '0;
    bus.cmd_wdata     = '0;
    bus.rsp_ready     = 1'b0;
    bus.m_apb_pready  = 1'b0;
    bus.m_apb_prdata  = '0;
    bus.m_apb_pslverr = 1'b0;
  endtask

  // One complete transfer. The slave raises pready on ACCESS cycle waits+1
  // (never reached if waits >= TIMEOUT), and the sink holds rsp_ready low
  // for rsp_delay response cycles.
  task automatic do_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int waits,
                         input logic err, input logic [DATA_W-1:0] rdata,
                         input int rsp_delay);
    logic [W-1:0]      exp_rsp;
    logic [W-1:0]      got;
    logic [W-1:0]      hold;
    logic [DATA_W-1:0] exp_pwdata;
    int                acc;
    int                exp_acc;

    exp_pwdata = wr ? wdata : '0;
    if (waits >= TIMEOUT) begin
      exp_rsp = {1'b1, 1'b1, {DATA_W{1'b0}}};
      exp_acc = TIMEOUT;
    end else begin
      exp_rsp = {1'b0, err, (wr ? {DATA_W{1'b0}} : rdata)};
      exp_acc = waits + 1;
    end
    exp_q.push_back(exp_rsp);

    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL cmd_ready_idle: got %b expected 1", bus.cmd_ready);
    end

    bus.cmd_valid    = 1'b1;
    bus.cmd_write    = wr;
    bus.cmd_addr     = addr;
    bus.cmd_wdata    = wdata;
    bus.m_apb_pready = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = $urandom;
    bus.cmd_addr  = $urandom;

    // SETUP cycle
    n_checks++;
    if ({bus.m_apb_psel, bus.m_apb_penable, bus.cmd_ready} !== 3'b100 ||
        bus.m_apb_paddr !== addr || bus.m_apb_pwrite !== wr ||
        bus.m_apb_pwdata !== exp_pwdata) begin
      n_errors++;
      $display("FAIL setup_phase: got sel/en/rdy=%b%b%b addr=%h wr=%b wdata=%h expected 100 addr=%h wr=%b wdata=%h",
               bus.m_apb_psel, bus.m_apb_penable, bus.cmd_ready, bus.m_apb_paddr,
               bus.m_apb_pwrite, bus.m_apb_pwdata, addr, wr, exp_pwdata);
    end

    acc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!(bus.m_apb_psel && bus.m_apb_penable)) break;
      acc++;
      n_checks++;
      if (bus.m_apb_paddr !== addr || bus.m_apb_pwrite !== wr ||
          bus.m_apb_pwdata !== exp_pwdata || bus.cmd_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL access_stable: got addr=%h wr=%b wdata=%h rdy=%b expected addr=%h wr=%b wdata=%h rdy=0",
                 bus.m_apb_paddr, bus.m_apb_pwrite, bus.m_apb_pwdata, bus.cmd_ready,
                 addr, wr, exp_pwdata);
      end
      if (acc == waits + 1) begin
        bus.m_apb_pready  = 1'b1;
        bus.m_apb_pslverr = err;
        bus.m_apb_prdata  = rdata;
      end else begin
        // junk on signals that must be ignored without pready
        bus.m_apb_pready  = 1'b0;
        bus.m_apb_pslverr = 1'($urandom_range(0, 1));
        bus.m_apb_prdata  = $urandom;
      end
    end
    bus.m_apb_pready  = 1'b0;
    bus.m_apb_pslverr = 1'b0;

    n_checks++;
    if (acc != exp_acc) begin
      n_errors++;
      $display("FAIL access_cycles: got %0d expected %0d", acc, exp_acc);
    end

    n_checks++;
    if ({bus.rsp_valid, bus.m_apb_psel, bus.m_apb_penable} !== 3'b100) begin
      n_errors++;
      $display("FAIL rsp_entry: got valid/sel/en=%b%b%b expected 100",
               bus.rsp_valid, bus.m_apb_psel, bus.m_apb_penable);
    end

    hold = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
    for (int d = 0; d < rsp_delay; d++) begin
      bus.rsp_ready = 1'b0;
      step();
      got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || got !== hold || bus.cmd_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL rsp_hold: got valid=%b rsp=%h rdy=%b expected valid=1 rsp=%h rdy=0",
                 bus.rsp_valid, got, bus.cmd_ready, hold);
      end
    end

    bus.rsp_ready = 1'b1;
    got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got response %h expected none queued", got);
    end else begin
      exp_rsp = exp_q.pop_front();
      if (got !== exp_rsp) begin
        n_errors++;
        $display("FAIL rsp_data: got {to,err,rdata}=%h expected %h", got, exp_rsp);
      end
    end
    step();
    bus.rsp_ready = 1'b0;

    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL back_to_idle: got valid=%b rdy=%b state=%0d expected 0 1 %0d",
               bus.rsp_valid, bus.cmd_ready, dbg_state, IDLE);
    end
  endtask

  // ---------------------------------------------------------------------
  // scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    resetn = 1'b1;
    repeat (3) step();
    resetn = 1'b0;
    n_checks++;
    if ({bus.m_apb_paddr, bus.m_apb_psel, bus.m_apb_penable, bus.m_apb_pwrite,
         bus.m_apb_pwdata, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
         bus.rsp_timeout} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got addr=%h sel=%b en=%b wr=%b wdata=%h rv=%b rd=%h err=%b to=%b expected all 0",
               bus.m_apb_paddr, bus.m_apb_psel, bus.m_apb_penable, bus.m_apb_pwrite,
               bus.m_apb_pwdata, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL reset_ready: got rdy=%b state=%0d expected 1 %0d",
               bus.cmd_ready, dbg_state, IDLE);
    end
  endtask

  task automatic test_write();
    do_xfer(1'b1, REG_LAST_ROW, 32'h13, 0, 1'b0, 32'h0, 0);
  endtask

  task automatic test_read_err();
    do_xfer(1'b0, REG_WEIGHT_XFER, 32'hDEAD_BEEF, 0, 1'b1, 32'h0, 0);
    do_xfer(1'b0, REG_ACT_ADDR, 32'h1111_2222, 1, 1'b0, 32'hCAFE_1234, 1);
  endtask

  task automatic test_wait_states();
    do_xfer(1'b1, REG_BATCH, 32'h2A, 3, 1'b0, 32'h0, 0);
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, REG_SYS_START, 32'h0, 100, 1'b0, 32'h55AA_55AA, 2);
    do_xfer(1'b1, REG_LAST_COL, 32'h7, 0, 1'b0, 32'h0, 0);
    // pready on the last allowed cycle wins over the abort
    do_xfer(1'b0, REG_LAST_COL, 32'h0, TIMEOUT - 1, 1'b0, 32'h0000_1234, 0);
    // pready one cycle too late: counter must have restarted from zero
    do_xfer(1'b0, REG_ACT_ADDR, 32'h0, TIMEOUT, 1'b0, 32'hFFFF_0000, 0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] hold;
    logic [W-1:0] got;
    logic [W-1:0] exp_rsp;

    bus.m_apb_pready  = 1'b1;
    bus.m_apb_pslverr = 1'b0;
    bus.m_apb_prdata  = 32'h0BAD_F00D;
    bus.rsp_ready     = 1'b0;
    exp_q.push_back({1'b0, 1'b0, {DATA_W{1'b0}}});
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = REG_ACT_ADDR;
    bus.cmd_wdata = 32'h0000_ABCD;
    step();
    // second command presented immediately and held
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = REG_BATCH;
    bus.cmd_wdata = 32'h0;
    step();
    step();
    hold = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
    for (int i = 0; i < 5; i++) begin
      got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || got !== hold || bus.cmd_ready !== 1'b0 ||
          bus.m_apb_psel !== 1'b0 || bus.m_apb_paddr !== REG_ACT_ADDR) begin
        n_errors++;
        $display("FAIL b2b_hold: got valid=%b rsp=%h rdy=%b sel=%b addr=%h expected 1 %h 0 0 %h",
                 bus.rsp_valid, got, bus.cmd_ready, bus.m_apb_psel, bus.m_apb_paddr,
                 hold, REG_ACT_ADDR);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
    exp_rsp = exp_q.pop_front();
    n_checks++;
    if (got !== exp_rsp) begin
      n_errors++;
      $display("FAIL b2b_first_rsp: got %h expected %h", got, exp_rsp);
    end
    step();
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.m_apb_psel !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_gap: got rdy=%b sel=%b rv=%b expected 1 0 0",
               bus.cmd_ready, bus.m_apb_psel, bus.rsp_valid);
    end
    exp_q.push_back({1'b0, 1'b0, 32'h0BAD_F00D});
    step();
    bus.cmd_valid = 1'b0;
    n_checks++;
    if ({bus.m_apb_psel, bus.m_apb_penable} !== 2'b10 ||
        bus.m_apb_paddr !== REG_BATCH || bus.m_apb_pwrite !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_second_setup: got sel/en=%b%b addr=%h wr=%b expected 10 %h 0",
               bus.m_apb_psel, bus.m_apb_penable, bus.m_apb_paddr, bus.m_apb_pwrite, REG_BATCH);
    end
    step();
    step();
    bus.rsp_ready = 1'b1;
    got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
    exp_rsp = exp_q.pop_front();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || got !== exp_rsp) begin
      n_errors++;
      $display("FAIL b2b_second_rsp: got valid=%b rsp=%h expected 1 %h",
               bus.rsp_valid, got, exp_rsp);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int seen;
    idle_inputs();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = REG_LAST_COL;
    step();
    bus.cmd_valid = 1'b0;
    step();
    n_checks++;
    if ({bus.m_apb_psel, bus.m_apb_penable} !== 2'b11) begin
      n_errors++;
      $display("FAIL rst_mid_access: got sel/en=%b%b expected 11",
               bus.m_apb_psel, bus.m_apb_penable);
    end
    resetn = 1'b1;
    step();
    resetn = 1'b0;
    n_checks++;
    if ({bus.m_apb_psel, bus.m_apb_penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0001) begin
      n_errors++;
      $display("FAIL rst_mid_drop: got sel/en/rv/rdy=%b%b%b%b expected 0001",
               bus.m_apb_psel, bus.m_apb_penable, bus.rsp_valid, bus.cmd_ready);
    end
    bus.m_apb_pready = 1'b1;
    bus.rsp_ready    = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.rsp_valid === 1'b1 || bus.m_apb_psel === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL rst_mid_no_rsp: got %0d active cycles expected 0", seen);
    end
    idle_inputs();
    do_xfer(1'b1, REG_SYS_START, 32'h1, 0, 1'b0, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] regs [6];
    regs[0] = REG_WEIGHT_XFER; regs[1] = REG_LAST_ROW; regs[2] = REG_LAST_COL;
    regs[3] = REG_SYS_START;   regs[4] = REG_ACT_ADDR; regs[5] = REG_BATCH;
    for (int n = 0; n < 20; n++) begin
      do_xfer(1'($urandom_range(0, 1)), regs[$urandom_range(0, 5)], $urandom,
              int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), $urandom,
              int'($urandom_range(0, 3)));
    end
  endtask

  // ---------------------------------------------------------------------
  // sequence and report
  // ---------------------------------------------------------------------
  initial begin
    test_reset();
    test_write();
    test_read_err();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
